// File: rtl/embedding_packer.sv
// Packs N_ELEM sign/magnitude elements into one wide vector for the dot-product stage.
// Latency: vector presented the cycle after its final accept; backpressure: in_ready is low while a vector is held.
// Option EMBEDDING_PACKER_SHORT_EN: in_last closes a vector early (zero-filled) and pulses err_short.
module embedding_packer #(
    parameter int N_ELEM = 10,
    parameter int MAG_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAG_W-1:0]          in_mag,
    input  logic                      in_sign,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_ELEM*MAG_W-1:0]   out_mag,
    output logic [N_ELEM-1:0]         out_sign,
    output logic                      err_short
);

    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N_ELEM*MAG_W-1:0]   mag_q, mag_d;
    logic [N_ELEM-1:0]         sign_q, sign_d;
    logic                      accept;
    logic                      short_end;

    assign accept = (state_q == FILL) && in_valid;

`ifdef EMBEDDING_PACKER_SHORT_EN
    logic err_q, err_d;

    // Unwritten slots are already zero: the vector store is cleared on every transfer and reset.
    assign short_end = accept && in_last && (idx_q != LAST_IDX);
    assign err_short = err_q;
`else
    logic unused_in_last;

    assign short_end      = 1'b0;
    assign unused_in_last = in_last;
    assign err_short      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
`ifdef EMBEDDING_PACKER_SHORT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            FILL: begin
                if (accept) begin
                    for (int i = 0; i < N_ELEM; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            mag_d[i*MAG_W +: MAG_W] = in_mag;
                            sign_d[i]               = in_sign;
                        end
                    end
                    if ((idx_q == LAST_IDX) || short_end) begin
                        state_d = HOLD;
                        idx_d   = '0;
`ifdef EMBEDDING_PACKER_SHORT_EN
                        err_d   = short_end;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                    idx_d   = '0;
                    mag_d   = '0;
                    sign_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            mag_q   <= '0;
            sign_q  <= '0;
`ifdef EMBEDDING_PACKER_SHORT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
`ifdef EMBEDDING_PACKER_SHORT_EN
            err_q   <= err_d;
`endif
        end
    end

    // in_ready is gated by rst_n so it drops the moment reset asserts.
    assign in_ready  = rst_n && (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign out_mag   = mag_q;
    assign out_sign  = sign_q;

endmodule

// File: tb/tb_embedding_packer.sv
// Directed bench for embedding_packer with a queue scoreboard of expected packed vectors.
module tb_embedding_packer;

    localparam int N = 10;
    localparam int W = 4;
`ifdef EMBEDDING_PACKER_SHORT_EN
    localparam bit SHORT = 1'b1;
`else
    localparam bit SHORT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_mag;
    logic           in_sign;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_mag;
    logic [N-1:0]   out_sign;
    logic           err_short;

    typedef struct packed {
        logic [N*W-1:0] mag;
        logic [N-1:0]   sign;
    } vec_t;

    int   vectors = 0;
    int   errs    = 0;
    int   cyc     = 0;
    vec_t sb_q[$];
    vec_t model;
    vec_t last_vec;
    vec_t mon_e;
    int   midx = 0;
    int   done_cyc;
    bit   done;
    int   prev_cyc;

    embedding_packer #(.N_ELEM(N), .MAG_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_sign   (in_sign),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_sign  (out_sign),
        .err_short (err_short)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output side of the scoreboard: every transfer must match the oldest expected vector.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("sb_mag", 64'(out_mag), 64'(mon_e.mag));
                check("sb_sign", 64'(out_sign), 64'(mon_e.sign));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] m, input logic s, input logic l);
        bit acc;
        bit was_short;
        acc  = 1'b0;
        done = 1'b0;
        in_valid = 1'b1;
        in_mag   = m;
        in_sign  = s;
        in_last  = l;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 64'(acc), 64'd1);
        if (acc) begin
            model.mag[midx*W +: W] = m;
            model.sign[midx]       = s;
            was_short = SHORT && l && (midx != N - 1);
            if (midx == N - 1 || was_short) begin
                sb_q.push_back(model);
                last_vec = model;
                model    = '0;
                midx     = 0;
                done     = 1'b1;
                done_cyc = cyc;
                check("ov_rise", 64'(out_valid), 64'd1);
                check("err_short", 64'(err_short), 64'(was_short));
            end else begin
                midx++;
                check("ov_early", 64'(out_valid), 64'd0);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_mag", 64'(out_mag), 64'd0);
        check("rst_out_sign", 64'(out_sign), 64'd0);
        check("rst_err_short", 64'(err_short), 64'd0);
        model = '0;
        midx  = 0;
        sb_q.delete();
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_rel_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mag    = '0;
        in_sign   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model     = '0;
        last_vec  = '0;
        step();
        do_reset();

        // Basic vector, mag=i+1 sign=i[0], drained immediately.
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) send(W'(i + 1), i[0], 1'b0);
        idle();
        check("basic_mag", 64'(out_mag), 64'h00_A987654321);
        check("basic_sign", 64'(out_sign), 64'(10'b1010101010));
        step();
        check("basic_post_ov", 64'(out_valid), 64'd0);
        check("basic_post_mag", 64'(out_mag), 64'd0);
        check("basic_post_ir", 64'(in_ready), 64'd1);

        // Held vector under backpressure.
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        idle();
        for (int c = 0; c < 5; c++) begin
            check("hold_ov", 64'(out_valid), 64'd1);
            check("hold_ir", 64'(in_ready), 64'd0);
            check("hold_mag", 64'(out_mag), 64'(last_vec.mag));
            check("hold_sign", 64'(out_sign), 64'(last_vec.sign));
            step();
        end
        out_ready = 1'b1;
        step();
        check("release_ov", 64'(out_valid), 64'd0);
        check("release_mag", 64'(out_mag), 64'd0);
        check("release_sign", 64'(out_sign), 64'd0);
        check("release_ir", 64'(in_ready), 64'd1);

        // Gapped input: one idle cycle between elements.
        for (int i = 0; i < N; i++) begin
            send(4'hF, i[0], 1'b0);
            idle();
            if (i < N - 1) begin
                step();
                check("gap_ov", 64'(out_valid), 64'd0);
            end
        end
        check("gap_mag", 64'(out_mag), 64'h00_FFFFFFFFFF);
        step();

        // in_last on the third element.
        send(4'h5, 1'b0, 1'b0);
        send(4'h5, 1'b0, 1'b0);
        send(4'h5, 1'b0, 1'b1);
        if (SHORT) begin
            idle();
            check("short_mag", 64'(out_mag), 64'h00_0000000555);
            step();
            check("short_err_drop", 64'(err_short), 64'd0);
            check("short_ov_drop", 64'(out_valid), 64'd0);
        end else begin
            for (int i = 3; i < N; i++) send(4'h5, 1'b0, 1'b0);
            idle();
            check("nolast_mag", 64'(out_mag), 64'h00_5555555555);
            step();
        end

        // Reset part way through a fill, then a clean vector.
        for (int i = 0; i < 6; i++) send(4'hC, 1'b1, 1'b0);
        idle();
        do_reset();
        for (int i = 0; i < N; i++) send(W'(i * 3 + 1), !i[0], 1'b0);
        idle();
        step();

        // Reset while a vector is held: it must never transfer.
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(4'h9, 1'b1, 1'b0);
        idle();
        step();
        do_reset();
        out_ready = 1'b1;
        step();
        step();
        check("rst_hold_discard", 64'(out_valid), 64'd0);

        // Back-to-back vectors with in_valid and out_ready held high.
        prev_cyc = -1;
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < N; i++) begin
                send(W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
                if (done) begin
                    if (prev_cyc >= 0) check("b2b_period", 64'(done_cyc - prev_cyc), 64'd11);
                    prev_cyc = done_cyc;
                end
            end
        end
        idle();
        step();
        step();
        check("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
